// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: per-stage payload widths
// and the occupancy counter width.
package pipe_pkg;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 118;
  localparam int EXMEM_W = 69;
  localparam int MEMWB_W = 67;

  localparam int OCC_W = 2;

  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/pipe_entry.sv
// One payload slot: N-bit data register plus valid bit.
// Priority is reset/clear, then load, then drop.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int N          = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic         drop,
  input  logic [N-1:0] load_data,
  output logic         valid,
  output logic [N-1:0] data
);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      valid <= 1'b0;
      if (CLEAR_DATA) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, optional skid
// entry, bubble-inserting hold and flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int N          = 32,
  parameter bit SKID       = 1'b1,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  input  logic             flush,
  input  logic             hold,
  output logic [OCC_W-1:0] occupancy
);

  logic         m_valid;
  logic         s_valid;
  logic [N-1:0] m_data;
  logic [N-1:0] m_src;
  logic         m_load;
  logic         m_drop;
  logic         in_fire;
  logic         out_fire;

  assign out_valid = m_valid & ~hold;
  assign out_data  = m_data;
  assign out_fire  = out_valid & out_ready;
  assign in_fire   = in_valid & in_ready;
  assign occupancy = OCC_W'(m_valid) + OCC_W'(s_valid);

  pipe_entry #(.N(N), .CLEAR_DATA(CLEAR_DATA)) u_main (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (flush),
    .load     (m_load),
    .drop     (m_drop),
    .load_data(m_src),
    .valid    (m_valid),
    .data     (m_data)
  );

  generate
    if (SKID) begin : g_skid
      logic [N-1:0] s_data;
      logic         s_load;
      logic         s_drop;
      logic         m_free;

      // in_ready comes only from flops plus hold/flush, breaking the out_ready path
      assign in_ready = ~s_valid & ~hold & ~flush;
      assign m_free   = ~m_valid | out_fire;

      assign m_load = ~hold & m_free & (s_valid | in_fire);
      assign m_drop = ~hold & m_free & ~s_valid & ~in_fire;
      assign m_src  = s_valid ? s_data : in_data;
      assign s_load = ~hold & ~m_free & in_fire;
      assign s_drop = ~hold & m_free & s_valid;

      pipe_entry #(.N(N), .CLEAR_DATA(CLEAR_DATA)) u_skid (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (flush),
        .load     (s_load),
        .drop     (s_drop),
        .load_data(in_data),
        .valid    (s_valid),
        .data     (s_data)
      );
    end else begin : g_single
      assign in_ready = (~m_valid | out_ready) & ~hold & ~flush;
      assign s_valid  = 1'b0;
      assign m_load   = in_fire;
      assign m_drop   = out_fire & ~in_fire;
      assign m_src    = in_data;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 N=32 instance and a SKID=0 N=64 instance,
// each compared every cycle against a queue-based reference model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        hold;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference state: FIFO contents and the value left in the main data register
  logic [31:0] qa[$];
  logic [63:0] qb[$];
  logic [31:0] da;
  logic [63:0] db;

  pipe_stage_reg #(.N(32), .SKID(1'b1), .CLEAR_DATA(1'b1)) u_a (
    .clock(clock), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(flush), .hold(hold), .occupancy(a_occ)
  );

  pipe_stage_reg #(.N(IFID_W), .SKID(1'b0), .CLEAR_DATA(1'b1)) u_b (
    .clock(clock), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(flush), .hold(hold), .occupancy(b_occ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit chk_en);
    bit a_rdy, b_rdy;
    #1;
    a_rdy = (qa.size() < 2) && !hold && !flush;
    b_rdy = ((qb.size() == 0) || b_out_ready) && !hold && !flush;
    if (chk_en) begin
      chk("a_in_ready",  64'(a_in_ready),  64'(a_rdy));
      chk("a_out_valid", 64'(a_out_valid), 64'((qa.size() > 0) && !hold));
      chk("a_out_data",  64'(a_out_data),  64'(da));
      chk("a_occupancy", 64'(a_occ),       64'(qa.size()));
      chk("a_skid_implies_main", 64'(u_a.s_valid & ~u_a.m_valid), 64'(0));
      chk("b_in_ready",  64'(b_in_ready),  64'(b_rdy));
      chk("b_out_valid", 64'(b_out_valid), 64'((qb.size() > 0) && !hold));
      chk("b_out_data",  b_out_data,       db);
      chk("b_occupancy", 64'(b_occ),       64'(qb.size()));
    end
    if (!reset_n || flush) begin
      qa.delete(); qb.delete();
      da = '0; db = '0;
    end else if (!hold) begin
      bit a_of, b_of;
      a_of = (qa.size() > 0) && a_out_ready;
      b_of = (qb.size() > 0) && b_out_ready;
      if (a_of) void'(qa.pop_front());
      if (a_in_valid && a_rdy) qa.push_back(a_in_data);
      if (qa.size() > 0) da = qa[0];
      if (b_of) void'(qb.pop_front());
      if (b_in_valid && b_rdy) qb.push_back(b_in_data);
      if (qb.size() > 0) db = qb[0];
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle_inputs();
    flush = 0; hold = 0;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    da = '0; db = '0;

    // reset with a payload offered on the inputs
    a_in_valid = 1; a_in_data = 32'hDEADBEEF;
    b_in_valid = 1; b_in_data = 64'hDEADBEEF_DEADBEEF;
    step(0);
    step(1);
    reset_n = 1;
    idle_inputs();
    step(1);

    // streaming at full rate
    a_out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 1; a_in_data = 32'(i);
      step(1);
    end
    a_in_valid = 0;
    step(1); step(1);

    // backpressure fills the skid entry
    a_in_valid = 1; a_in_data = 32'hA; a_out_ready = 1; step(1);
    a_in_data = 32'hB; a_out_ready = 0; step(1);
    a_in_data = 32'hC; step(1);
    a_in_valid = 0; step(1);
    a_out_ready = 1; step(1); step(1); step(1);

    // hold freezes a stored payload
    a_in_valid = 1; a_in_data = 32'h55; a_out_ready = 0; step(1);
    a_in_data = 32'h66; hold = 1;
    step(1); step(1); step(1);
    hold = 0; a_in_valid = 0; a_out_ready = 1; step(1); step(1);

    // flush a full stage while a new payload is offered
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h11; step(1);
    a_in_data = 32'h22; step(1);
    a_in_data = 32'h33; flush = 1; step(1);
    flush = 0; a_in_valid = 0; a_out_ready = 1; step(1); step(1);

    // flush and hold together: flush wins
    a_in_valid = 1; a_in_data = 32'h44; a_out_ready = 0; step(1);
    a_in_valid = 0; flush = 1; hold = 1; step(1);
    flush = 0; hold = 0; step(1);

    // reset in the middle of traffic
    a_in_valid = 1; a_in_data = 32'h77; step(1);
    a_in_data = 32'h88; reset_n = 0; step(1);
    reset_n = 1; a_in_valid = 0; a_out_ready = 1; step(1);

    // single-entry instance: out_ready gates in_ready combinationally
    idle_inputs();
    b_in_valid = 1; b_in_data = 64'h1111_2222_3333_4444; step(1);
    b_in_data = 64'h5555_6666_7777_8888; step(1);
    b_out_ready = 1; step(1);
    b_in_valid = 0; step(1); step(1);

    // randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      reset_n     = ($urandom_range(0, 99) >= 2);
      flush       = ($urandom_range(0, 99) < 5);
      hold        = ($urandom_range(0, 99) < 10);
      a_in_valid  = ($urandom_range(0, 99) < 70);
      a_in_data   = $urandom;
      a_out_ready = ($urandom_range(0, 99) < 60);
      b_in_valid  = ($urandom_range(0, 99) < 70);
      b_in_data   = {$urandom, $urandom};
      b_out_ready = ($urandom_range(0, 99) < 60);
      step(1);
    end

    reset_n = 1;
    idle_inputs();
    a_out_ready = 1; b_out_ready = 1;
    step(1); step(1); step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline-stage register, successor to the plain write/flush stage register used between IF/ID, ID/EX, EX/MEM and MEM/WB.
- Adds a valid/ready handshake, an optional 2-entry skid buffer that registers backpressure, a bubble-inserting hold, and flush.
- Sits between any two pipeline stages. The hazard unit drives hold; the branch/jump logic drives flush.

Parameters:
- N, 32, payload width in bits (>=1).
- SKID, 1, 1 = main and skid entry with registered in_ready; 0 = single entry with combinational in_ready.
- CLEAR_DATA, 1, 1 = reset and flush zero the data registers; 0 = reset and flush clear only the valid bits.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage accepts payload this cycle
- in_data  in  N  upstream payload
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream accepts payload
- out_data  out  N  payload from main entry
- flush  in  1  discard all held payloads
- hold  in  1  freeze stage and present a bubble downstream
- occupancy  out  2  number of valid entries (0..2; max 1 when SKID=0)

Behaviour:
- State: main entry M (m_valid, m_data). When SKID=1, also skid entry S (s_valid, s_data).
- Priority on each rising edge: reset > flush > hold > normal transfer.
- Reset (reset_n=0 at the edge):
  - m_valid=s_valid=0.
  - Data registers zeroed if CLEAR_DATA=1.
  - After reset: out_valid=0, occupancy=0, out_data=0 (CLEAR_DATA=1), in_ready=1.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- out_valid = m_valid & ~hold. out_data = m_data (always driven, even when invalid).
- in_ready:
  - SKID=1: in_ready = ~s_valid & ~hold & ~flush. Depends only on registered state plus hold/flush; no path from out_ready.
  - SKID=0: in_ready = (~m_valid | out_ready) & ~hold & ~flush.
- Flush:
  - Next state m_valid=s_valid=0; data zeroed if CLEAR_DATA=1.
  - in_ready=0 in the flush cycle, so no input is accepted.
  - A payload on the output in that cycle is still consumed if out_ready=1. This matches a branch resolving while the older instruction leaves.
- Hold:
  - All registers keep their values.
  - out_valid=0 and in_ready=0, so no transfer occurs on either side.
  - Hold may last any number of cycles; the contents reappear unchanged when hold drops.
- Normal transfer, SKID=1:
  - M empty or out_fire, with S valid: M<=S, S invalid. in_fire is impossible because in_ready=0.
  - M empty or out_fire, with S empty: M<=in_data when in_fire, else m_valid<=0.
  - M valid, no out_fire, in_fire: S<=in_data, s_valid<=1. This is the case where out_ready dropped in the same cycle.
  - Otherwise hold state.
  - Ordering: FIFO, no drop, no duplication. Throughput is 1 payload/cycle when out_ready is held 1.
- Normal transfer, SKID=0: M<=in_data on in_fire; m_valid<=0 on out_fire without in_fire.
- occupancy = m_valid + s_valid, registered. Invariant: s_valid implies m_valid (assert in bench).
- Latency: in_fire on edge k gives out_valid=1 in the cycle after edge k (1 cycle), in both modes.
- Boundaries:
  - Full (occupancy 2) with out_ready=0: in_ready=0, state static.
  - Full with out_ready=1: M<=S, in_ready=1 from the following cycle.
  - Simultaneous flush and hold: flush wins.
  - Reset asserted mid-transfer: everything is lost, no partial state.

Decomposition:
- Shared package pipe_pkg:
  - payload-width constants for the four stages: IFID_W=64, IDEX_W=118, EXMEM_W=69, MEMWB_W=67.
  - occupancy width constant OCC_W=2.
- One natural sub-module: pipe_entry (N-bit data register plus valid bit, with load/clear/clear_data controls), instantiated as M and S.
- Mode selection by generate on SKID.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, occupancy=0, out_data=0, in_ready=1 after release.
- Streaming: out_ready=1, push 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on consecutive cycles, each one cycle after acceptance, occupancy constant 1.
- Backpressure (SKID=1): push 0xA then 0xB with out_ready=0 from the second cycle -> occupancy=2, in_ready=0. Raise out_ready -> outputs 0xA then 0xB, no loss.
- Hold: stage holds 0x55, hold=1 for 3 cycles -> out_valid=0, in_ready=0, state static. Drop hold -> out_valid=1, out_data=0x55.
- Flush: occupancy=2 (0x11, 0x22), flush=1 with in_valid=1, in_data=0x33 -> next cycle occupancy=0, out_valid=0, out_data=0 (CLEAR_DATA=1), and 0x33 is never emitted.
- SKID=0 instance, N=64: out_ready=0 with M valid -> in_ready=0. Toggle out_ready=1 -> in_ready=1 in the same cycle, replacement accepted, occupancy stays 1.
